// File: rtl/pulse_sched_pkg.sv
// Shared types, parameter defaults and helpers for the pulse scheduler.
package pulse_sched_pkg;

    localparam int N_REQ_DEF     = 4;
    localparam int MAX_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Bits needed to hold a width value in the range 0..max_width.
    function automatic int calc_width_w(input int max_width);
        return $clog2(max_width + 1);
    endfunction

endpackage

// File: rtl/pulse_sched_rr_pick.sv
// Combinational round-robin picker: first set pending bit at or after ptr, with wrap.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int SEL_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] pending,
    input  logic [SEL_W-1:0] ptr,
    output logic             valid,
    output logic [SEL_W-1:0] idx
);

    // Scan from the farthest offset down to ptr so the closest candidate wins.
    always_comb begin
        int cand;
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = int'(ptr) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (pending[cand]) begin
                valid = 1'b1;
                idx   = SEL_W'(cand);
            end
        end
    end

endmodule

// File: rtl/pulse_sched.sv
// Round-robin scheduler sharing one widened pulse output among several requesters.
module pulse_sched
    import pulse_sched_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int MAX_WIDTH = MAX_WIDTH_DEF,
    parameter int WIDTH_W   = calc_width_w(MAX_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_i,
    input  logic                     cfg_we,
    input  logic [$clog2(N_REQ)-1:0] cfg_sel,
    input  logic [WIDTH_W-1:0]       cfg_width,
    output logic                     pulse_o,
    output logic [$clog2(N_REQ)-1:0] grant_id_o,
    output logic                     busy_o,
    output logic [N_REQ-1:0]         pending_o,
    output logic                     drop_o
);

    localparam int SEL_W = $clog2(N_REQ);

    state_t             state_q, state_d;
    logic [WIDTH_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   grant_id_q, grant_id_d;
    logic [N_REQ-1:0]   pending_q, pending_d;
    logic               drop_q, drop_d;
    logic               pulse_q, pulse_d;
    logic               busy_q, busy_d;
    logic [WIDTH_W-1:0] width_q [N_REQ];
    logic [WIDTH_W-1:0] width_d [N_REQ];

    logic               pick_valid;
    logic [SEL_W-1:0]   pick_idx;
    logic               grant;
    logic               cfg_sel_ok;
    logic [WIDTH_W-1:0] cfg_width_clamped;

    rr_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .pending (pending_q),
        .ptr     (ptr_q),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    // A grant happens on any edge where the output is free and something is pending.
    assign grant = pick_valid && ((state_q == IDLE) || (state_q == GAP));

    assign cfg_sel_ok        = (int'(cfg_sel) < N_REQ);
    assign cfg_width_clamped = (cfg_width > WIDTH_W'(MAX_WIDTH)) ? WIDTH_W'(MAX_WIDTH) : cfg_width;

    // State register and all other flops; reset forces every output low immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            grant_id_q <= '0;
            pending_q  <= '0;
            drop_q     <= 1'b0;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
            for (int k = 0; k < N_REQ; k++) begin
                width_q[k] <= WIDTH_W'(1);
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
            for (int k = 0; k < N_REQ; k++) begin
                width_q[k] <= width_d[k];
            end
        end
    end

    // Next state and pulse-length down-counter; the width is sampled only at grant.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = PULSE;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - WIDTH_W'(1);
                end
            end
            GAP: begin
                state_d = grant ? PULSE : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (grant) begin
            cnt_d = width_q[pick_idx] - WIDTH_W'(1);
        end
    end

    // Registered outputs derived from the upcoming state, plus grant id and pointer update.
    always_comb begin
        pulse_d    = (state_d == PULSE);
        busy_d     = (state_d != IDLE);
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        if (grant) begin
            grant_id_d = pick_idx;
            ptr_d      = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + SEL_W'(1);
        end
    end

    // Pending flags: grant clears, a same-edge request re-arms, disabled or duplicate requests drop.
    always_comb begin
        pending_d = pending_q;
        drop_d    = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant && (int'(pick_idx) == k)) begin
                pending_d[k] = 1'b0;
            end
            if (req_i[k]) begin
                if (width_q[k] == '0) begin
                    drop_d = 1'b1;
                end else if (pending_q[k] && !(grant && (int'(pick_idx) == k))) begin
                    drop_d = 1'b1;
                end else begin
                    pending_d[k] = 1'b1;
                end
            end
            if (cfg_we && cfg_sel_ok && (int'(cfg_sel) == k) && (cfg_width_clamped == '0)) begin
                pending_d[k] = 1'b0;
            end
        end
    end

    // Width register file with clamping on write.
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            width_d[k] = width_q[k];
        end
        if (cfg_we && cfg_sel_ok) begin
            width_d[cfg_sel] = cfg_width_clamped;
        end
    end

    assign pulse_o    = pulse_q;
    assign grant_id_o = grant_id_q;
    assign busy_o     = busy_q;
    assign pending_o  = pending_q;
    assign drop_o     = drop_q;

endmodule

// File: doc/pulse_sched.md
# pulse_sched

Round-robin scheduler that shares a single widened-pulse output among `N_REQ` requesters. Each requester issues single-cycle request strobes; the block latches them as pending, grants one channel at a time, and drives one output pulse whose width is programmed per channel, followed by a mandatory one-cycle gap. It sits in front of downstream logic that needs stretched strobes, such as slow-clock sampling or LED/debug drive, and replaces per-channel pulse-widening instances.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `MAX_WIDTH`, 16: largest programmable pulse width, in cycles.
- `WIDTH_W`, `$clog2(MAX_WIDTH+1)`: width of the config field (derived; do not override).
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_i` input `N_REQ`: request strobes, one bit per channel; any cycle high counts as one request.
- `cfg_we` input 1: write strobe for a channel width register.
- `cfg_sel` input `$clog2(N_REQ)`: channel selected for the write.
- `cfg_width` input `WIDTH_W`: width in cycles; 0 disables the channel; values above `MAX_WIDTH` clamp to `MAX_WIDTH`.
- `pulse_o` output 1: widened pulse.
- `grant_id_o` output `$clog2(N_REQ)`: channel owning the current or last pulse.
- `busy_o` output 1: high in PULSE and GAP.
- `pending_o` output `N_REQ`: registered pending flags.
- `drop_o` output 1: one-cycle flag; a request was discarded.

## Operation
- Pending flags:
  - A `req_i[k]` high at an edge sets `pending[k]`.
  - If `pending[k]` is already set, or width[k] is 0, the request is discarded and `drop_o` is high the following cycle. Several drops in one cycle give a single `drop_o`.
  - Granting channel k clears `pending[k]` at the grant edge. A new `req_i[k]` at that same edge wins: `pending[k]` stays 1 and no drop is flagged.
- Width registers:
  - Written on a `cfg_we` edge; reset value 1 for all channels.
  - The width used for a pulse is latched at grant. A write during a pulse affects only later grants.
  - Writing 0 to a channel with a pending request clears that pending flag at the write edge, with no drop flagged.
- Arbitration:
  - Round-robin with pointer `ptr`; search starts at `ptr`, ascending with wrap. After a grant to k, `ptr = (k+1) mod N_REQ`.
  - Reset value of `ptr` is 0.
- FSM states:
  - IDLE → PULSE when any pending flag is set.
  - PULSE: hold for width cycles using down-counter `cnt`, loaded with width−1 at grant. When `cnt == 0` → GAP.
  - GAP lasts exactly one cycle, with `pulse_o` low. GAP → PULSE if any flag is pending, else → IDLE.
- `pulse_o` is high exactly when the state is PULSE. `grant_id_o` updates at the grant edge and holds until the next grant.

## Timing
- All outputs are registered.
- Reset values: `pulse_o`=0, `grant_id_o`=0, `busy_o`=0, `pending_o`=0, `drop_o`=0, state=IDLE, `cnt`=0, `ptr`=0, widths=1.
- Latency when idle: `req_i` high at edge E0 gives `pending` set after E0, and `pulse_o` high after E1. That is 2 cycles from the request cycle to the first pulse cycle.
- Back-to-back pulses: for widths w1 and w2, `pulse_o` is high for w1 cycles, low for 1 cycle, then high for w2 cycles.
- `rst_n` low mid-pulse forces all outputs to their reset values immediately (asynchronously). Pending requests are lost. Operation resumes on the first edge after deassertion.
- Simultaneous requests on all channels with ptr=0: grant order is 0,1,2,3.

## Structure
- Package `pulse_sched_pkg`:
  - `state_t` enum {IDLE, PULSE, GAP}.
  - Parameter defaults and the `WIDTH_W` helper function.
- Sub-module `rr_pick`: purely combinational.
  - Inputs: pending vector, `ptr`.
  - Outputs: `valid`, `idx`.
  - Parameterized by `N_REQ`.
- The top level holds the FSM, counter, width register file, pending flags and drop logic.

## Test plan
- Single request: reset, then `req_i`=0001 for 1 cycle with width[0]=1 (default). Expect `pulse_o` high for exactly 1 cycle, 2 cycles after the request; `grant_id_o`=0; `busy_o` high for 2 cycles.
- Widths 4/2/3: set channels 0/1/2 to 4/2/3, pulse `req_i`=0111 for one cycle. Expect `pulse_o` sequence 1111 0 11 0 111, `grant_id_o` 0→1→2, then IDLE.
- Round-robin fairness: hold `req_i[0]` and `req_i[3]` high continuously, both widths 2. Expect grants to alternate 0,3,0,3. `drop_o` is high on cycles where a request hits an already-set pending flag.
- Re-request at grant edge: `req_i[1]` strobed at the edge channel 1 is granted. Expect `pending_o[1]`=1 afterwards, no `drop_o`, and a second channel-1 pulse after GAP.
- Config edges: write width 0 to channel 2, then request it. Expect a `drop_o` pulse and no output pulse. Write width 8 to channel 1 mid-pulse of its width-2 grant; expect the current pulse to stay 2 cycles and the next to be 8.
- Reset mid-pulse: assert `rst_n`=0 during cycle 2 of a width-4 pulse. Expect `pulse_o`, `busy_o` and `pending_o` to go 0 immediately, and no pulse after release until a new request arrives.
